// File: rtl/instr_prefetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_prefetch_unit                                                      |
// | Pipelined instruction prefetcher: up to DEPTH outstanding memory reads,   |
// | DEPTH-entry {instr, pc} FIFO towards decode, single redirect port.        |
// | Optional: PREFETCH_PERF_CNT_EN adds oFetchCount / oStallCount.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module instr_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              iClk,
  input  logic              iRst_n,
  output logic [ADDR_W-1:0] oInstrMemAddress,
  output logic              oInstrMemValid,
  input  logic              iInstrMemReady,
  input  logic [DATA_W-1:0] iInstrMemData,
  input  logic              iInstrMemRespValid,
  input  logic              iRedirect,
  input  logic [ADDR_W-1:0] iRedirectAddr,
  input  logic              iHalt,
  output logic [DATA_W-1:0] oInstruction,
  output logic [ADDR_W-1:0] oPC,
  output logic [ADDR_W-1:0] oNextPC,
  output logic              oValid,
  input  logic              iReady
`ifdef PREFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       oFetchCount,
  output logic [31:0]       oStallCount
`endif
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam int unsigned       DEPTH_U = DEPTH;
  localparam logic [CNT_W:0]    DEPTH_V = DEPTH_U[CNT_W:0];

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            rState, wStateNext;
  logic [ADDR_W-1:0] rFetchPC;
  logic [DATA_W-1:0] rDataMem [DEPTH];
  logic [ADDR_W-1:0] rAddrMem [DEPTH];
  logic [PTR_W-1:0]  rWrPtr, rRdPtr;
  logic [CNT_W-1:0]  rCount, rOutstanding, rDropCnt;
  logic [CNT_W:0]    wInUse;
  logic [CNT_W-1:0]  wOutNext;
  logic              wHasCredit, wAccept, wDeq, wEnq, wDrop;

  // Credit covers buffered words plus every response still owed, dropped ones included
  assign wInUse     = {1'b0, rCount} + {1'b0, rOutstanding};
  assign wHasCredit = wInUse < DEPTH_V;
  assign wAccept    = oInstrMemValid & iInstrMemReady;
  assign oValid     = (rCount != '0);
  assign wDeq       = oValid & iReady;
  assign wEnq       = iInstrMemRespValid & ~iRedirect & (rDropCnt == '0);
  assign wDrop      = iInstrMemRespValid & ~iRedirect & (rDropCnt != '0);
  assign wOutNext   = rOutstanding + CNT_W'(wAccept) - CNT_W'(iInstrMemRespValid);

  assign oInstrMemAddress = rFetchPC;
  assign oInstruction     = rDataMem[rRdPtr];
  assign oPC              = rAddrMem[rRdPtr];
  assign oNextPC          = rAddrMem[rRdPtr] + ADDR_W'(1);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) rState <= RUN;
    else         rState <= wStateNext;
  end

  always_comb begin
    wStateNext     = rState;
    oInstrMemValid = 1'b0;
    case (rState)
      RUN: begin
        if (iHalt) wStateNext = HALT;
        else       oInstrMemValid = iRst_n & ~iRedirect & wHasCredit;
      end
      HALT:    if (!iHalt) wStateNext = RUN;
      default: wStateNext = RUN;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rFetchPC     <= RESET_PC;
      rOutstanding <= '0;
      rDropCnt     <= '0;
    end else begin
      rOutstanding <= wOutNext;
      if (iRedirect) begin
        rFetchPC <= iRedirectAddr;
        rDropCnt <= wOutNext;
      end else begin
        if (wAccept) rFetchPC <= rFetchPC + ADDR_W'(1);
        if (wDrop)   rDropCnt <= rDropCnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rCount <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rDataMem[i] <= '0;
        rAddrMem[i] <= '0;
      end
    end else if (iRedirect) begin
      rRdPtr <= rWrPtr;
      rCount <= '0;
    end else begin
      if (wEnq) begin
        rDataMem[rWrPtr] <= iInstrMemData;
        rAddrMem[rWrPtr] <= rFetchPC - ADDR_W'(rOutstanding - rDropCnt);
        rWrPtr           <= rWrPtr + PTR_W'(1);
      end
      if (wDeq) rRdPtr <= rRdPtr + PTR_W'(1);
      rCount <= rCount + CNT_W'(wEnq) - CNT_W'(wDeq);
    end
  end

`ifdef PREFETCH_PERF_CNT_EN
  logic [31:0] rFetchCount, rStallCount;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rFetchCount <= '0;
      rStallCount <= '0;
    end else begin
      if (wDeq && rFetchCount != '1)               rFetchCount <= rFetchCount + 32'd1;
      if (iReady && !oValid && rStallCount != '1) rStallCount <= rStallCount + 32'd1;
    end
  end

  assign oFetchCount = rFetchCount;
  assign oStallCount = rStallCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
`default_nettype none
// Bench for instr_prefetch_unit: in-order memory model with configurable latency,
// epoch-based reference queue of words decode must see, directed scenarios.
module tb_instr_prefetch_unit;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic [31:0] KEY    = 32'hC0DE_0000;

  logic              iClk = 1'b0;
  logic              iRst_n = 1'b0;
  logic [ADDR_W-1:0] oInstrMemAddress;
  logic              oInstrMemValid;
  logic              iInstrMemReady = 1'b0;
  logic [DATA_W-1:0] iInstrMemData = '0;
  logic              iInstrMemRespValid = 1'b0;
  logic              iRedirect = 1'b0;
  logic [ADDR_W-1:0] iRedirectAddr = '0;
  logic              iHalt = 1'b0;
  logic [DATA_W-1:0] oInstruction;
  logic [ADDR_W-1:0] oPC, oNextPC;
  logic              oValid;
  logic              iReady = 1'b0;
`ifdef PREFETCH_PERF_CNT_EN
  logic [31:0]       oFetchCount, oStallCount;
`endif

  instr_prefetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .oInstrMemAddress(oInstrMemAddress), .oInstrMemValid(oInstrMemValid),
    .iInstrMemReady(iInstrMemReady), .iInstrMemData(iInstrMemData),
    .iInstrMemRespValid(iInstrMemRespValid),
    .iRedirect(iRedirect), .iRedirectAddr(iRedirectAddr), .iHalt(iHalt),
    .oInstruction(oInstruction), .oPC(oPC), .oNextPC(oNextPC),
    .oValid(oValid), .iReady(iReady)
`ifdef PREFETCH_PERF_CNT_EN
    , .oFetchCount(oFetchCount), .oStallCount(oStallCount)
`endif
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        memQ[$];
  req_t        curResp;
  logic [31:0] mFifo[$];
  logic [31:0] delivered[$];
  logic [31:0] deliveredNext[$];
  logic [31:0] mFetchPC = RST_PC;
  logic [31:0] lastPC;
  bit          mHaltPrev = 1'b0;
  bit          checkEn = 1'b0;
  bit          expIssue;
  int          cycle = 0;
  int          epoch = 0;
  int          memLat = 1;
  int          acceptCnt = 0;
  int          mDeqCnt = 0;
  int          inFlight;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  // Instruction memory: answers strictly in request order after memLat cycles
  always @(posedge iClk) begin
    cycle++;
    #1;
    iInstrMemRespValid = 1'b0;
    iInstrMemData      = '0;
    if (iRst_n && memQ.size() > 0 && memQ[0].due <= cycle) begin
      curResp            = memQ.pop_front();
      iInstrMemRespValid = 1'b1;
      iInstrMemData      = memWord(curResp.addr);
    end
  end

  // Reference: words of the current epoch reach decode in order, one cycle after return
  always @(negedge iClk) begin
    if (checkEn) begin
      expIssue = !iHalt && !mHaltPrev && !iRedirect &&
                 (mFifo.size() + memQ.size() + int'(iInstrMemRespValid) < DEPTH);
      check("memValid", {31'd0, oInstrMemValid}, {31'd0, expIssue});
      if (expIssue) check("memAddr", oInstrMemAddress, mFetchPC);
      check("oValid", {31'd0, oValid}, {31'd0, mFifo.size() > 0});
      if (mFifo.size() > 0) begin
        check("oPC", oPC, mFifo[0]);
        check("oInstruction", oInstruction, memWord(mFifo[0]));
        check("oNextPC", oNextPC, mFifo[0] + 32'd1);
      end
`ifdef PREFETCH_PERF_CNT_EN
      check("fetchCount", oFetchCount, mDeqCnt);
`endif
      if (oValid && iReady) begin
        delivered.push_back(oPC);
        deliveredNext.push_back(oNextPC);
        mDeqCnt++;
        if (mFifo.size() > 0) void'(mFifo.pop_front());
      end
      if (oInstrMemValid && iInstrMemReady) begin
        req_t r;
        r.addr  = oInstrMemAddress;
        r.epoch = epoch;
        r.due   = cycle + memLat;
        memQ.push_back(r);
        acceptCnt++;
        mFetchPC = mFetchPC + 32'd1;
      end
      if (iInstrMemRespValid && !iRedirect && curResp.epoch == epoch)
        mFifo.push_back(curResp.addr);
      if (iRedirect) begin
        mFifo.delete();
        epoch++;
        mFetchPC = iRedirectAddr;
      end
      mHaltPrev = iHalt;
    end
  end

  task automatic doReset();
    checkEn   = 1'b0;
    iRst_n    = 1'b0;
    iRedirect = 1'b0;
    iHalt     = 1'b0;
    tick(1);
    memQ.delete();
    mFifo.delete();
    @(negedge iClk);
    check("rst_memValid", {31'd0, oInstrMemValid}, 32'd0);
    check("rst_oValid", {31'd0, oValid}, 32'd0);
    check("rst_oInstruction", oInstruction, 32'd0);
    check("rst_oPC", oPC, 32'd0);
    check("rst_oNextPC", oNextPC, 32'd1);
    tick(1);
    iRst_n    = 1'b1;
    mFetchPC  = RST_PC;
    mHaltPrev = 1'b0;
    epoch++;
    acceptCnt = 0;
    mDeqCnt   = 0;
    delivered.delete();
    deliveredNext.delete();
    checkEn   = 1'b1;
  endtask

  initial begin
    // 1: streaming from RESET_PC with 1-cycle memory
    memLat = 1;
    iInstrMemReady = 1'b1;
    iReady = 1'b1;
    doReset();
    tick(2);
    @(negedge iClk);
    check("t1_firstValid", {31'd0, oValid}, 32'd1);
    check("t1_firstPC", oPC, 32'h100);
    check("t1_firstInstr", oInstruction, 32'hC0DE_0100);
    tick(8);
    check("t1_pc0", delivered[0], 32'h100);
    check("t1_pc1", delivered[1], 32'h101);
    check("t1_pc2", delivered[2], 32'h102);

    // 2: decode stalled -> exactly DEPTH requests, FIFO holds 0x100..0x103
    iReady = 1'b0;
    doReset();
    tick(12);
    check("t2_accepts", acceptCnt, 32'd4);
    @(negedge iClk);
    check("t2_noIssue", {31'd0, oInstrMemValid}, 32'd0);
    check("t2_headPC", oPC, 32'h100);
    tick(1);
    iReady = 1'b1;
    tick(6);
    for (int i = 0; i < 4; i++) check("t2_drain", delivered[i], 32'h100 + i);

    // 3: redirect with two responses in flight
    memLat = 2;
    tick(10);
    iRedirect = 1'b1;
    iRedirectAddr = 32'h2000;
    @(negedge iClk);
    inFlight = memQ.size() + int'(iInstrMemRespValid);
    check("t3_inFlight", inFlight, 32'd2);
    tick(1);
    iRedirect = 1'b0;
    delivered.delete();
    tick(8);
    check("t3_first", delivered[0], 32'h2000);
    check("t3_second", delivered[1], 32'h2001);

    // 4: address wrap
    iRedirect = 1'b1;
    iRedirectAddr = 32'hFFFF_FFFF;
    tick(1);
    iRedirect = 1'b0;
    delivered.delete();
    deliveredNext.delete();
    tick(8);
    check("t4_lastPC", delivered[0], 32'hFFFF_FFFF);
    check("t4_lastNext", deliveredNext[0], 32'h0);
    check("t4_wrapPC", delivered[1], 32'h0);

    // 5: halt stops issue, buffer drains, resume at next address
    iHalt = 1'b1;
    acceptCnt = 0;
    tick(8);
    check("t5_haltAccepts", acceptCnt, 32'd0);
    @(negedge iClk);
    check("t5_drained", {31'd0, oValid}, 32'd0);
    lastPC = delivered[delivered.size()-1];
    tick(1);
    iHalt = 1'b0;
    delivered.delete();
    tick(8);
    check("t5_resume", delivered[0], lastPC + 32'd1);

    // 6: memory ready toggling
    acceptCnt = 0;
    delivered.delete();
    for (int i = 0; i < 16; i++) begin
      iInstrMemReady = (i % 2 == 0);
      tick(1);
    end
    check("t6_accepts", acceptCnt, 32'd8);
    iInstrMemReady = 1'b1;
    tick(6);
    for (int i = 0; i + 1 < delivered.size(); i++)
      check("t6_order", delivered[i+1], delivered[i] + 32'd1);

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
